// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank responder: NUM_REGS word registers with byte strobes.
// Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           NUM_REGS    = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      s0_axi_aclk,
    input  logic                      s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
    input  logic                      s0_axi_awvalid,
    output logic                      s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
    input  logic                      s0_axi_wvalid,
    output logic                      s0_axi_wready,
    output logic [1:0]                s0_axi_bresp,
    output logic                      s0_axi_bvalid,
    input  logic                      s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_araddr,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [DATA_WIDTH-1:0]     s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic [1:0] {WIdle, WHaveAddr, WHaveData, WResp} wstate_e;
    typedef enum logic       {RIdle, RData} rstate_e;

    function automatic logic idx_ok(input logic [IDX_WIDTH-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    // Sub-word address bits select nothing; unaligned accesses hit the containing word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s0_axi_awaddr[ADDR_LSB-1:0], s0_axi_araddr[ADDR_LSB-1:0]};

    logic [IDX_WIDTH-1:0] aw_idx, ar_idx;
    assign aw_idx = s0_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx = s0_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Write channel state
    wstate_e               wstate_q, wstate_d;
    logic [IDX_WIDTH-1:0]  awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // Read channel state
    rstate_e               rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic [IDX_WIDTH-1:0]  cm_idx;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_WIDTH-1:0] cm_strb;
    logic [DATA_WIDTH-1:0] rd_word;

    assign aw_hs = s0_axi_awvalid & awready_q;
    assign w_hs  = s0_axi_wvalid & wready_q;
    assign ar_hs = s0_axi_arvalid & arready_q;

    always_comb begin
        wstate_d  = wstate_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        cm_idx    = aw_idx;
        cm_data   = s0_axi_wdata;
        cm_strb   = s0_axi_wstrb;
        unique case (wstate_q)
            WIdle: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    awidx_d   = aw_idx;
                    awready_d = 1'b0;
                    wstate_d  = WHaveAddr;
                end else if (w_hs) begin
                    wdata_d  = s0_axi_wdata;
                    wstrb_d  = s0_axi_wstrb;
                    wready_d = 1'b0;
                    wstate_d = WHaveData;
                end
            end
            WHaveAddr: begin
                cm_idx = awidx_q;
                commit = w_hs;
            end
            WHaveData: begin
                cm_data = wdata_q;
                cm_strb = wstrb_q;
                commit  = aw_hs;
            end
            WResp: begin
                if (bvalid_q && s0_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
        if (commit) begin
            bvalid_d  = 1'b1;
            bresp_d   = idx_ok(cm_idx) ? RESP_OKAY : RESP_OOR;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            wstate_d  = WResp;
        end
    end

    // Out-of-range commits match no register and are dropped.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (commit && (32'(cm_idx) == r)) begin
                for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                    if (cm_strb[b]) regs_d[r][8*b +: 8] = cm_data[8*b +: 8];
                end
            end
        end
    end

    // Reads sample regs_q, so a same-edge write commit is not yet visible.
    always_comb begin
        rd_word = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (32'(ar_idx) == r) rd_word = regs_q[r];
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (rstate_q)
            RIdle: begin
                if (ar_hs) begin
                    rdata_d   = rd_word;
                    rresp_d   = idx_ok(ar_idx) ? RESP_OKAY : RESP_OOR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = RData;
                end
            end
            RData: begin
                if (s0_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = RIdle;
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            wstate_q  <= WIdle;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rstate_q  <= RIdle;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= RESET_VALUE;
        end else begin
            wstate_q  <= wstate_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign s0_axi_awready = awready_q;
    assign s0_axi_wready  = wready_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_arready = arready_q;
    assign s0_axi_rvalid  = rvalid_q;
    assign s0_axi_rdata   = rdata_q;
    assign s0_axi_rresp   = rresp_q;

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) register bank: terminates the master-side AXI-Lite port of the bus interconnect and implements NUM_REGS word-wide read/write registers.
- Accepts AW and W independently in any order, applies byte strobes, returns B and R responses with full valid/ready handshakes.
- Decodes out-of-range addresses.
- Used as the target peripheral behind the interconnect, and as a bench responder.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (32 or 64).
- ADDR_WIDTH, 8, byte address width.
- NUM_REGS, 4, number of implemented registers (1..2^(ADDR_WIDTH-ADDR_LSB)).
- RESET_VALUE, 0, reset value of every register.

Ports:
- s0_axi_aclk  in  1  clock
- s0_axi_aresetn  in  1  asynchronous active-low reset
- s0_axi_awaddr  in  ADDR_WIDTH  write byte address
- s0_axi_awvalid  in  1  write address valid
- s0_axi_awready  out  1  write address ready
- s0_axi_wdata  in  DATA_WIDTH  write data
- s0_axi_wstrb  in  DATA_WIDTH/8  byte write enables
- s0_axi_wvalid  in  1  write data valid
- s0_axi_wready  out  1  write data ready
- s0_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s0_axi_bvalid  out  1  write response valid
- s0_axi_bready  in  1  write response ready
- s0_axi_araddr  in  ADDR_WIDTH  read byte address
- s0_axi_arvalid  in  1  read address valid
- s0_axi_arready  out  1  read address ready
- s0_axi_rdata  out  DATA_WIDTH  read data
- s0_axi_rresp  out  2  read response
- s0_axi_rvalid  out  1  read data valid
- s0_axi_rready  in  1  read data ready

Behaviour:
- Clock and reset: one clock, s0_axi_aclk. Reset s0_axi_aresetn is asynchronous, active-low.
- Reset values:
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0.
  - All registers = RESET_VALUE.
  - Buffered address/data discarded.
  - Reset mid-transaction drops every pending handshake immediately; no response is ever issued for it.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8); index = addr[ADDR_WIDTH-1:ADDR_LSB].
  - Low ADDR_LSB bits are ignored (unaligned addresses map to the containing word).
  - In range: index < NUM_REGS.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W handshake on the same edge: commit, go to W_RESP.
    - AW only: latch address, awready<=0, go to W_HAVE_ADDR.
    - W only: latch wdata/wstrb, wready<=0, go to W_HAVE_DATA.
  - W_HAVE_ADDR: awready=0. On W handshake: commit, go to W_RESP.
  - W_HAVE_DATA: wready=0. On AW handshake: commit, go to W_RESP.
  - Commit, done on the completing edge:
    - For each byte i with wstrb[i]=1, reg[index] byte i <= wdata byte i.
    - bvalid<=1, bresp set by the decode.
    - awready<=0, wready<=0.
    - wstrb=0 is a legal no-op that still returns OKAY.
  - W_RESP: hold bvalid and bresp stable until bready. On the bvalid&&bready edge: bvalid<=0, awready<=1, wready<=1, go to W_IDLE.
  - Latency: bvalid is high the cycle after the completing handshake. Maximum write rate is one per 2 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake:
    - rdata <= reg[index], or 0 if out of range.
    - rresp set by the decode.
    - rvalid<=1, arready<=0, go to R_DATA.
  - R_DATA: hold rdata, rresp and rvalid stable until rready. On the handshake edge: rvalid<=0, arready<=1, go to R_IDLE.
  - Latency: rvalid is high the cycle after the AR handshake.
- Read and write FSMs are fully independent and may run concurrently.
- Same-edge collision: an AR handshake on the same edge as a write commit to the same register returns the pre-write value.
- No outstanding-transaction depth beyond 1 per channel direction. The master must not see awready/wready/arready high while a response is pending.

Optional Feature:
- Macro AXIL_REG_SLVERR_EN.
- Defined: out-of-range write returns bresp=10 and registers are unchanged; out-of-range read returns rresp=10 and rdata=0.
- Undefined: out-of-range accesses return 00 (OKAY). Writes are silently dropped and reads return 0.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then AW=0x04 and W=0xDEADBEEF with strb=1111 on the same cycle, bready=1 -> bvalid high exactly one cycle later with bresp=00. Read of 0x04 -> rdata=0xDEADBEEF, rresp=00, one cycle after AR.
- W=0x11223344 presented 3 cycles before AW=0x08 -> wready low after W accept, no bvalid until the AW handshake, bvalid the cycle after it. Read of 0x08 returns 0x11223344.
- reg0=0xAABBCCDD, then write 0x00000099 with strb=0001 to 0x00 -> reg0 reads 0xAABBCC99. A subsequent write with strb=0000 leaves 0xAABBCC99 and returns OKAY.
- bready held low 5 cycles after a write -> bvalid and bresp stable all 5 cycles, awready/wready low. A second AW offered during this window is not accepted until the cycle after the B handshake.
- Write to 0x40 (index 16 >= NUM_REGS=4), then read 0x40 -> with AXIL_REG_SLVERR_EN: bresp=10, rresp=10, rdata=0. Without it: 00/00, rdata=0. In both builds regs 0..3 are unchanged.
- Assert reset while bvalid is pending and an AR has been accepted -> bvalid=0 and rvalid=0 immediately (asynchronously), all readies=1, regs=RESET_VALUE, and no response is issued after reset release.
